// File: rtl/dsi_hs_lane_rx.sv
// ---------------------------------------------------------------------------
// dsi_hs_lane_rx
// Receive side of one DSI HS data lane. Takes 8-bit words from the lane
// deserializer, hunts for the HS sync byte at any of 8 bit offsets, locks
// the alignment for the rest of the burst, forwards the aligned payload and
// discards the HS-trail bytes at the end of the burst.
//
// Ports
//   clk_sys    in   byte clock, all logic on posedge
//   rst_n      in   asynchronous active-low reset
//   hs_input   in   [7:0] deserialized word, bit0 earliest on the wire
//   hs_valid   in   lane is in HS mode, hs_input meaningful
//   out_data   out  [7:0] aligned payload byte
//   out_valid  out  out_data valid this cycle
//   out_sof    out  with out_valid: first payload byte of the burst
//   out_eof    out  1-cycle end-of-burst pulse, no data attached
//   active     out  high while a burst is being handled (HUNT/ACTIVE/DROP)
//   sync_err   out  1-cycle pulse when no sync byte was found
// ---------------------------------------------------------------------------
module dsi_hs_lane_rx #(
    parameter logic [7:0] SYNC_SEQUENCE = 8'b00011101,
    parameter int         TRAIL_BYTES   = 2,
    parameter int         SYNC_TIMEOUT  = 4
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic [7:0] hs_input,
    input  logic       hs_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_sof,
    output logic       out_eof,
    output logic       active,
    output logic       sync_err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HUNT   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_DROP   = 2'd3;

    localparam int HUNT_W     = $clog2(SYNC_TIMEOUT + 1);
    localparam int FILL_W     = $clog2(TRAIL_BYTES + 1);
    localparam int LINE_DEPTH = (TRAIL_BYTES > 1) ? TRAIL_BYTES - 1 : 1;
    localparam int OLD_IDX    = LINE_DEPTH - 1;

    logic [1:0]        state;
    logic [7:0]        prev_r;
    logic [2:0]        offset;
    logic [HUNT_W-1:0] hunt_cnt;
    logic [FILL_W-1:0] fill_cnt;
    logic [7:0]        line_r [LINE_DEPTH];
    logic              sof_pending;

    logic [15:0] window;
    logic        match_found;
    logic [2:0]  match_k;
    logic [7:0]  aligned;
    logic        line_full;
    logic [7:0]  oldest;

    assign window = {hs_input, prev_r};
    assign active = (state != ST_IDLE);

    // Scan downwards so the lowest matching offset is the one that sticks.
    always_comb begin
        match_found = 1'b0;
        match_k     = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (window[k +: 8] == SYNC_SEQUENCE) begin
                match_found = 1'b1;
                match_k     = 3'(k);
            end
        end
    end

    // The delay line is TRAIL_BYTES deep counting the byte currently being
    // assembled in the window (its low bits live in prev_r). Only the older
    // TRAIL_BYTES-1 bytes need real storage, and the oldest of the whole line
    // is the aligned byte itself when TRAIL_BYTES is 1.
    assign aligned   = window[offset +: 8];
    assign line_full = (fill_cnt == FILL_W'(TRAIL_BYTES - 1));
    assign oldest    = (TRAIL_BYTES == 1) ? aligned : line_r[OLD_IDX];

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            prev_r      <= 8'd0;
            offset      <= 3'd0;
            hunt_cnt    <= '0;
            fill_cnt    <= '0;
            sof_pending <= 1'b0;
            out_data    <= 8'd0;
            out_valid   <= 1'b0;
            out_sof     <= 1'b0;
            out_eof     <= 1'b0;
            sync_err    <= 1'b0;
            for (int i = 0; i < LINE_DEPTH; i++) begin
                line_r[i] <= 8'd0;
            end
        end else begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            sync_err  <= 1'b0;

            if (hs_valid) begin
                prev_r <= hs_input;
            end

            case (state)
                ST_IDLE: begin
                    if (hs_valid) begin
                        state    <= ST_HUNT;
                        hunt_cnt <= '0;
                    end
                end

                ST_HUNT: begin
                    if (!hs_valid) begin
                        sync_err <= 1'b1;
                        state    <= ST_IDLE;
                    end else if (match_found) begin
                        offset      <= match_k;
                        fill_cnt    <= '0;
                        sof_pending <= 1'b1;
                        state       <= ST_ACTIVE;
                    end else if (hunt_cnt == HUNT_W'(SYNC_TIMEOUT - 1)) begin
                        sync_err <= 1'b1;
                        state    <= ST_DROP;
                    end else begin
                        hunt_cnt <= hunt_cnt + 1'b1;
                    end
                end

                ST_ACTIVE: begin
                    if (!hs_valid) begin
                        // Whatever is still in the line is HS-trail.
                        fill_cnt <= '0;
                        out_eof  <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        line_r[0] <= aligned;
                        for (int i = 1; i < LINE_DEPTH; i++) begin
                            line_r[i] <= line_r[i-1];
                        end
                        if (line_full) begin
                            out_data    <= oldest;
                            out_valid   <= 1'b1;
                            out_sof     <= sof_pending;
                            sof_pending <= 1'b0;
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    if (!hs_valid) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsi_hs_lane_rx.sv
// ---------------------------------------------------------------------------
// tb_dsi_hs_lane_rx
// Self-checking bench for dsi_hs_lane_rx. Bursts are queued as word lists;
// a bit-stream reference model finds the sync position and derives the
// expected per-cycle outputs, which are compared against the DUT.
// ---------------------------------------------------------------------------
module tb_dsi_hs_lane_rx;

    localparam logic [7:0] SYNC    = 8'b00011101;
    localparam int         TRAIL   = 2;
    localparam int         TIMEOUT = 4;

    logic       clk_sys = 1'b0;
    logic       rst_n;
    logic [7:0] hs_input;
    logic       hs_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_sof;
    logic       out_eof;
    logic       active;
    logic       sync_err;

    always #5 clk_sys = ~clk_sys;

    dsi_hs_lane_rx #(
        .SYNC_SEQUENCE (SYNC),
        .TRAIL_BYTES   (TRAIL),
        .SYNC_TIMEOUT  (TIMEOUT)
    ) dut (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .hs_input  (hs_input),
        .hs_valid  (hs_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .active    (active),
        .sync_err  (sync_err)
    );

    int checks = 0;
    int errors = 0;

    bit         stim_valid [$];
    logic [7:0] stim_data  [$];
    bit         exp_valid  [$];
    bit         exp_sof    [$];
    bit         exp_eof    [$];
    bit         exp_err    [$];
    bit         exp_active [$];
    logic [7:0] exp_data   [$];
    logic [7:0] got_bytes  [$];
    logic [7:0] cur_words  [$];

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic w8(input logic [7:0] v);
        cur_words.push_back(v);
    endtask

    task automatic growTo(input int n);
        while (exp_valid.size() < n) begin
            exp_valid.push_back(1'b0);
            exp_sof.push_back(1'b0);
            exp_eof.push_back(1'b0);
            exp_err.push_back(1'b0);
            exp_active.push_back(1'b0);
            exp_data.push_back(8'h00);
        end
    endtask

    // Reference model: treat the burst as a bit stream (bit0 of each word
    // first). Hunt cycle j (1..) can see sync starting at bits 8(j-1)..8(j-1)+7.
    // Payload byte m starts 8+8m bits after the sync start; with TRAIL trail
    // bytes, n words give n-j-TRAIL output bytes, byte m leaving the DUT
    // TRAIL+m+1 cycles after the sync-found cycle j.
    task automatic modelBurst(input int s);
        bit         bits [$];
        logic [7:0] sync_v = SYNC;
        logic [7:0] b;
        int         n = cur_words.size();
        bit         found = 1'b0;
        int         jf = 0;
        int         pf = 0;
        int         nout;
        foreach (cur_words[i]) begin
            b = cur_words[i];
            for (int k = 0; k < 8; k++) bits.push_back(b[k]);
        end
        for (int j = 1; j <= TIMEOUT && j <= n - 1 && !found; j++) begin
            for (int k = 0; k < 8 && !found; k++) begin
                bit hit = 1'b1;
                int p = 8 * (j - 1) + k;
                for (int i = 0; i < 8; i++) if (bits[p + i] != sync_v[i]) hit = 1'b0;
                if (hit) begin
                    found = 1'b1;
                    jf    = j;
                    pf    = p;
                end
            end
        end
        growTo(s + n + 2);
        for (int c = s + 1; c <= s + n; c++) exp_active[c] = 1'b1;
        if (found) begin
            nout = n - jf - TRAIL;
            for (int m = 0; m < nout; m++) begin
                int c = s + jf + m + TRAIL + 1;
                for (int k = 0; k < 8; k++) b[k] = bits[pf + 8 + 8 * m + k];
                exp_valid[c] = 1'b1;
                exp_sof[c]   = (m == 0);
                exp_data[c]  = b;
            end
            exp_eof[s + n + 1] = 1'b1;
        end else if (n - 1 >= TIMEOUT) begin
            exp_err[s + TIMEOUT + 1] = 1'b1;
        end else begin
            exp_err[s + n + 1] = 1'b1;
        end
    endtask

    task automatic addBurst(input int gap);
        int s = stim_valid.size();
        foreach (cur_words[i]) begin
            stim_valid.push_back(1'b1);
            stim_data.push_back(cur_words[i]);
        end
        repeat (gap) begin
            stim_valid.push_back(1'b0);
            stim_data.push_back(8'($urandom));
        end
        growTo(stim_valid.size());
        modelBurst(s);
    endtask

    task automatic applyStimulus();
        int len;
        growTo(stim_valid.size());
        len = exp_valid.size();
        for (int t = 0; t < len; t++) begin
            @(posedge clk_sys);
            #1;
            hs_valid = (t < stim_valid.size()) ? stim_valid[t] : 1'b0;
            hs_input = (t < stim_data.size()) ? stim_data[t] : 8'h00;
            @(negedge clk_sys);
            checkOutput("out_valid", 8'(out_valid), 8'(exp_valid[t]));
            checkOutput("out_sof", 8'(out_sof), 8'(exp_sof[t]));
            checkOutput("out_eof", 8'(out_eof), 8'(exp_eof[t]));
            checkOutput("sync_err", 8'(sync_err), 8'(exp_err[t]));
            checkOutput("active", 8'(active), 8'(exp_active[t]));
            if (exp_valid[t]) checkOutput("out_data", out_data, exp_data[t]);
            if (out_valid) got_bytes.push_back(out_data);
        end
        stim_valid.delete();
        stim_data.delete();
        exp_valid.delete();
        exp_sof.delete();
        exp_eof.delete();
        exp_err.delete();
        exp_active.delete();
        exp_data.delete();
    endtask

    task automatic loadBurst1();
        cur_words.delete();
        w8(8'h00); w8(8'h1D); w8(8'hA5); w8(8'h3C); w8(8'h5A); w8(8'hFF); w8(8'hFF);
    endtask

    task automatic checkBytes(input string tag, input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2, input int n);
        logic [7:0] ev [3];
        ev[0] = e0; ev[1] = e1; ev[2] = e2;
        checkOutput({tag, " count"}, 8'(got_bytes.size()), 8'(n));
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, " byte"}, (i < got_bytes.size()) ? got_bytes[i] : 8'hxx, ev[i]);
        end
    endtask

    initial begin
        bit rb [$];
        logic [7:0] sync_v = SYNC;
        logic [7:0] wb;

        rst_n    = 1'b0;
        hs_valid = 1'b0;
        hs_input = 8'h00;
        repeat (2) @(posedge clk_sys);
        #1;
        checkOutput("reset out_valid", 8'(out_valid), 8'd0);
        checkOutput("reset out_data", out_data, 8'd0);
        checkOutput("reset active", 8'(active), 8'd0);
        checkOutput("reset sync_err", 8'(sync_err), 8'd0);
        checkOutput("reset out_eof", 8'(out_eof), 8'd0);
        @(negedge clk_sys);
        rst_n = 1'b1;

        // Aligned burst
        got_bytes.delete();
        loadBurst1();
        addBurst(2);
        applyStimulus();
        checkBytes("aligned", 8'hA5, 8'h3C, 8'h5A, 3);

        // Same bit stream shifted by 3 bits, trailing ones continued
        got_bytes.delete();
        cur_words.delete();
        w8(8'h00); w8(8'hE8); w8(8'h28); w8(8'hE5); w8(8'hD1); w8(8'hFA); w8(8'hFF);
        addBurst(2);
        applyStimulus();
        checkBytes("offset3", 8'hA5, 8'h3C, 8'h5A, 3);

        // Timeout, then short burst
        got_bytes.delete();
        cur_words.delete();
        repeat (5) w8(8'h00);
        addBurst(2);
        cur_words.delete();
        w8(8'h00); w8(8'h1D); w8(8'h11); w8(8'hFF);
        addBurst(2);
        applyStimulus();
        checkOutput("short burst bytes", 8'(got_bytes.size()), 8'd0);

        // Back-to-back bursts with a single idle cycle
        got_bytes.delete();
        loadBurst1();
        addBurst(1);
        cur_words.delete();
        w8(8'h00); w8(8'h1D); w8(8'h01); w8(8'h02); w8(8'hFE); w8(8'hFE);
        addBurst(2);
        applyStimulus();
        checkOutput("b2b count", 8'(got_bytes.size()), 8'd5);
        checkOutput("b2b byte3", (got_bytes.size() > 3) ? got_bytes[3] : 8'hxx, 8'h01);
        checkOutput("b2b byte4", (got_bytes.size() > 4) ? got_bytes[4] : 8'hxx, 8'h02);

        // Reset in the middle of a burst
        loadBurst1();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_sys);
            #1;
            hs_valid = 1'b1;
            hs_input = cur_words[i];
        end
        @(negedge clk_sys);
        checkOutput("pre-reset out_valid", 8'(out_valid), 8'd1);
        checkOutput("pre-reset out_data", out_data, 8'hA5);
        checkOutput("pre-reset active", 8'(active), 8'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid reset out_valid", 8'(out_valid), 8'd0);
        checkOutput("mid reset out_data", out_data, 8'd0);
        checkOutput("mid reset out_sof", 8'(out_sof), 8'd0);
        checkOutput("mid reset active", 8'(active), 8'd0);
        hs_valid = 1'b0;
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        rst_n = 1'b1;
        got_bytes.delete();
        loadBurst1();
        addBurst(2);
        applyStimulus();
        checkBytes("after reset", 8'hA5, 8'h3C, 8'h5A, 3);

        // Randomized bursts
        for (int batch = 0; batch < 4; batch++) begin
            for (int bn = 0; bn < 10; bn++) begin
                cur_words.delete();
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 8)) w8(8'($urandom));
                end else begin
                    rb.delete();
                    repeat ($urandom_range(0, 20)) rb.push_back(1'($urandom_range(0, 1)));
                    for (int i = 0; i < 8; i++) rb.push_back(sync_v[i]);
                    repeat ($urandom_range(0, 50)) rb.push_back(1'($urandom_range(0, 1)));
                    while (rb.size() % 8 != 0) rb.push_back(1'($urandom_range(0, 1)));
                    for (int w = 0; w < rb.size() / 8; w++) begin
                        for (int k = 0; k < 8; k++) wb[k] = rb[8 * w + k];
                        w8(wb);
                    end
                end
                addBurst($urandom_range(1, 3));
            end
            applyStimulus();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
